fpga_clk_div_gen: RTL and testbench



---
 rtl/fpga_clk_div_gen.sv | 133 +++++++++++++
 tb/tb_fpga_clk_div_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_clk_div_gen.sv
// Multi-channel clock-enable divider. Each channel has a small register file
// with a two-state handshake, a shadowed divider value, and a lock indicator.
// A new divider is applied only at a period boundary (or at once when the
// channel is disabled), so an enabled channel never emits a shortened period.
module fpga_clk_div_gen #(
    parameter int NUM_CH   = 3,
    parameter int DIV_W    = 8,
    parameter int LOCK_CYC = 16,
    parameter int DIV_RST  = 1
) (
    input  logic                    ref_clk_i,
    input  logic                    rst_glob_i,
    input  logic [NUM_CH-1:0]       cfg_req_i,
    input  logic [NUM_CH-1:0][4:0]  cfg_add_i,
    input  logic [NUM_CH-1:0]       cfg_wrn_i,
    input  logic [NUM_CH-1:0][31:0] cfg_data_i,
    output logic [NUM_CH-1:0]       cfg_ack_o,
    output logic [NUM_CH-1:0][31:0] cfg_r_data_o,
    output logic [NUM_CH-1:0]       cfg_lock_o,
    output logic [NUM_CH-1:0]       clk_en_o
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } cfgState_t;

    localparam logic [7:0]       LOCK_MAX = 8'(LOCK_CYC);
    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChan
        localparam logic [15:0] CH_ID = 16'(ch + 1);

        cfgState_t        state_q, state_d;
        logic             en_q, en_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] shadow_q, shadow_d;
        logic             pending_q, pending_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [7:0]       lockCnt_q, lockCnt_d;
        logic             ack_q, ack_d;
        logic [31:0]      rData_q, rData_d;
        logic             lock_q, lock_d;
        logic             clkEn_q, clkEn_d;
        logic             commit, wrap, apply, running;
        logic [DIV_W-1:0] wrDiv;
        logic             unusedData;

        // Upper write-data bits have no register behind them.
        assign unusedData = ^cfg_data_i[ch][31:DIV_W];

        // Next-state: handshake, register writes, divider apply, counters and
        // the values the registered outputs will show after this edge.
        always_comb begin
            commit    = (state_q == IDLE) && cfg_req_i[ch];
            wrap      = en_q && (cnt_q == div_q - DIV_W'(1));
            apply     = pending_q && (!en_q || wrap);
            state_d   = commit ? ACK : IDLE;
            ack_d     = commit;
            en_d      = en_q;
            shadow_d  = shadow_q;
            div_d     = apply ? shadow_q : div_q;
            pending_d = apply ? 1'b0 : pending_q;
            wrDiv     = cfg_data_i[ch][DIV_W-1:0];
            if (commit && !cfg_wrn_i[ch]) begin
                case (cfg_add_i[ch])
                    5'd0: en_d = cfg_data_i[ch][0];
                    5'd1: begin
                        shadow_d  = (wrDiv == '0) ? DIV_W'(1) : wrDiv;
                        pending_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            running = en_q && en_d;
            cnt_d   = (!running || wrap) ? '0 : cnt_q + DIV_W'(1);
            if (!running || apply) begin
                lockCnt_d = '0;
            end else if (lockCnt_q != LOCK_MAX) begin
                lockCnt_d = lockCnt_q + 8'd1;
            end else begin
                lockCnt_d = lockCnt_q;
            end
            lock_d  = en_d && (lockCnt_d == LOCK_MAX);
            clkEn_d = en_d && (cnt_d == div_d - DIV_W'(1));
            rData_d = '0;
            if (commit && cfg_wrn_i[ch]) begin
                case (cfg_add_i[ch])
                    5'd0:    rData_d = {31'b0, en_d};
                    5'd1:    rData_d = 32'(shadow_d);
                    5'd2:    rData_d = {30'b0, pending_d, lock_d};
                    5'd3:    rData_d = {CH_ID, 16'h0002};
                    default: rData_d = '0;
                endcase
            end
        end

        // Channel state and registered outputs; reset aborts any transaction.
        always_ff @(posedge ref_clk_i or posedge rst_glob_i) begin
            if (rst_glob_i) begin
                state_q   <= IDLE;
                en_q      <= 1'b1;
                div_q     <= DIV_INIT;
                shadow_q  <= DIV_INIT;
                pending_q <= 1'b0;
                cnt_q     <= '0;
                lockCnt_q <= '0;
                ack_q     <= 1'b0;
                rData_q   <= '0;
                lock_q    <= 1'b0;
                clkEn_q   <= 1'b0;
            end else begin
                state_q   <= state_d;
                en_q      <= en_d;
                div_q     <= div_d;
                shadow_q  <= shadow_d;
                pending_q <= pending_d;
                cnt_q     <= cnt_d;
                lockCnt_q <= lockCnt_d;
                ack_q     <= ack_d;
                rData_q   <= rData_d;
                lock_q    <= lock_d;
                clkEn_q   <= clkEn_d;
            end
        end

        assign cfg_ack_o[ch]    = ack_q;
        assign cfg_r_data_o[ch] = rData_q;
        assign cfg_lock_o[ch]   = lock_q;
        assign clk_en_o[ch]     = clkEn_q;
    end

endmodule

// File: tb/tb_fpga_clk_div_gen.sv
// Bench for fpga_clk_div_gen: a per-channel behavioural model advanced on every
// rising edge, a negedge compare process, directed scenarios pinned with
// literal values, and a randomized traffic phase.
module tb_fpga_clk_div_gen;

    localparam int NCH  = 3;
    localparam int DW   = 8;
    localparam int LOCK = 16;
    localparam int DRST = 1;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       cfgReq;
    logic [NCH-1:0][4:0]  cfgAdd;
    logic [NCH-1:0]       cfgWrn;
    logic [NCH-1:0][31:0] cfgData;
    logic [NCH-1:0]       cfgAck;
    logic [NCH-1:0][31:0] cfgRData;
    logic [NCH-1:0]       cfgLock;
    logic [NCH-1:0]       clkEn;

    int checks = 0;
    int errors = 0;
    bit checkOn = 0;

    // Model state: applied divider, shadow, pending, enable, position within
    // the current period, cycles since the last lock restart, handshake busy.
    int          mD[NCH], mShadow[NCH], mPhase[NCH], mAge[NCH];
    bit          mEn[NCH], mPend[NCH], mBusy[NCH];
    bit          mAck[NCH], mClk[NCH], mLock[NCH];
    logic [31:0] mRd[NCH];

    fpga_clk_div_gen #(
        .NUM_CH(NCH), .DIV_W(DW), .LOCK_CYC(LOCK), .DIV_RST(DRST)
    ) dut (
        .ref_clk_i(clock),
        .rst_glob_i(reset),
        .cfg_req_i(cfgReq),
        .cfg_add_i(cfgAdd),
        .cfg_wrn_i(cfgWrn),
        .cfg_data_i(cfgData),
        .cfg_ack_o(cfgAck),
        .cfg_r_data_o(cfgRData),
        .cfg_lock_o(cfgLock),
        .clk_en_o(clkEn)
    );

    // Free-running reference clock.
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int ch,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s ch%0d actual=0x%08h expected=0x%08h t=%0t",
                     name, ch, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int ch = 0; ch < NCH; ch++) begin
            mD[ch] = DRST; mShadow[ch] = DRST; mPhase[ch] = 0; mAge[ch] = 0;
            mEn[ch] = 1; mPend[ch] = 0; mBusy[ch] = 0;
            mAck[ch] = 0; mClk[ch] = 0; mLock[ch] = 0; mRd[ch] = '0;
        end
    endtask

    task automatic modelStep(input int ch);
        bit   start, boundary, take, newEn, newPend, keepGoing;
        int   newD, newSh, newPhase, newAge;
        logic [31:0] rd;
        start    = !mBusy[ch] && cfgReq[ch];
        boundary = mEn[ch] && (mPhase[ch] == mD[ch] - 1);
        take     = mPend[ch] && (!mEn[ch] || boundary);
        newD     = take ? mShadow[ch] : mD[ch];
        newPend  = take ? 1'b0 : mPend[ch];
        newEn    = mEn[ch];
        newSh    = mShadow[ch];
        if (start && !cfgWrn[ch]) begin
            if (cfgAdd[ch] == 5'd0) newEn = cfgData[ch][0];
            else if (cfgAdd[ch] == 5'd1) begin
                newSh   = int'(cfgData[ch] % (1 << DW));
                if (newSh == 0) newSh = 1;
                newPend = 1;
            end
        end
        keepGoing = mEn[ch] && newEn;
        newPhase  = keepGoing ? (mPhase[ch] + 1) % mD[ch] : 0;
        newAge    = (keepGoing && !take) ? ((mAge[ch] + 1 > LOCK) ? LOCK : mAge[ch] + 1) : 0;
        mD[ch] = newD; mShadow[ch] = newSh; mPend[ch] = newPend; mEn[ch] = newEn;
        mPhase[ch] = newPhase; mAge[ch] = newAge; mBusy[ch] = start;
        mLock[ch] = newEn && (newAge == LOCK);
        mClk[ch]  = newEn && (newPhase == newD - 1);
        mAck[ch]  = start;
        rd = '0;
        case (cfgAdd[ch])
            5'd0: rd = 32'(newEn);
            5'd1: rd = 32'(newSh);
            5'd2: rd = {30'b0, newPend, mLock[ch]};
            5'd3: rd = {16'(ch + 1), 16'h0002};
            default: rd = '0;
        endcase
        mRd[ch] = (start && cfgWrn[ch]) ? rd : '0;
    endtask

    // Advance the model on every rising edge; reset clears it asynchronously.
    always @(posedge clock or posedge reset) begin
        if (reset) modelReset();
        else for (int ch = 0; ch < NCH; ch++) modelStep(ch);
    end

    // Compare every DUT output against the model once per cycle.
    always @(negedge clock) begin
        if (checkOn) begin
            for (int ch = 0; ch < NCH; ch++) begin
                checkOutput("ack", ch, 32'(cfgAck[ch]), 32'(mAck[ch]));
                checkOutput("rdata", ch, cfgRData[ch], mRd[ch]);
                checkOutput("lock", ch, 32'(cfgLock[ch]), 32'(mLock[ch]));
                checkOutput("clkEn", ch, 32'(clkEn[ch]), 32'(mClk[ch]));
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic doTransaction(input int ch, input bit rd, input logic [4:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata);
        cfgReq[ch] = 1'b1; cfgWrn[ch] = rd; cfgAdd[ch] = addr; cfgData[ch] = wdata;
        @(negedge clock);
        checkOutput("ackLatency", ch, 32'(cfgAck[ch]), 32'd1);
        rdata = cfgRData[ch];
        cfgReq[ch] = 1'b0;
        @(negedge clock);
    endtask

    task automatic waitPulse(input int ch, input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!clkEn[ch] && waited < limit);
        checkOutput("pulseSeen", ch, 32'(clkEn[ch]), 32'd1);
    endtask

    task automatic applyStimulus();
        for (int ch = 0; ch < NCH; ch++) begin
            cfgReq[ch] = ($urandom_range(0, 3) == 0);
            cfgWrn[ch] = ($urandom_range(0, 4) < 3);
            if ($urandom_range(0, 7) == 0) cfgAdd[ch] = 5'($urandom_range(0, 31));
            else cfgAdd[ch] = 5'($urandom_range(0, 3));
            case (cfgAdd[ch])
                5'd0: cfgData[ch] = ($urandom() & 32'hFFFF_FFFE) | 32'($urandom_range(0, 3) != 0);
                5'd1: cfgData[ch] = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 7));
                default: cfgData[ch] = $urandom();
            endcase
        end
    endtask

    // Hard stop so the run can never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios, randomized traffic, then reset abort cases.
    initial begin
        logic [31:0] rd;
        int          w, g, acks;
        reset = 1'b1;
        cfgReq = '0; cfgAdd = '0; cfgWrn = '0; cfgData = '0;
        waitCycles(3);
        checkOn = 1;
        for (int ch = 0; ch < NCH; ch++) begin
            checkOutput("rstAck", ch, 32'(cfgAck[ch]), 32'd0);
            checkOutput("rstClkEn", ch, 32'(clkEn[ch]), 32'd0);
            checkOutput("rstLock", ch, 32'(cfgLock[ch]), 32'd0);
        end
        reset = 1'b0;

        waitCycles(15);
        for (int ch = 0; ch < NCH; ch++) checkOutput("lockCyc15", ch, 32'(cfgLock[ch]), 32'd0);
        waitCycles(1);
        for (int ch = 0; ch < NCH; ch++) begin
            checkOutput("lockCyc16", ch, 32'(cfgLock[ch]), 32'd1);
            checkOutput("clkEnDiv1", ch, 32'(clkEn[ch]), 32'd1);
        end

        acks = 0;
        cfgReq = '1; cfgWrn = '1;
        for (int ch = 0; ch < NCH; ch++) cfgAdd[ch] = 5'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            for (int ch = 0; ch < NCH; ch++) begin
                if (cfgAck[ch]) begin
                    if (ch == 0) acks++;
                    checkOutput("idData", ch, cfgRData[ch], 32'h0002 | (32'(ch + 1) << 16));
                end
            end
        end
        cfgReq = '0;
        checkOutput("idAckCount", 0, 32'(acks), 32'd2);
        waitCycles(1);

        doTransaction(2, 1'b0, 5'd0, 32'd0, rd);
        doTransaction(2, 1'b0, 5'd1, 32'd0, rd);
        doTransaction(2, 1'b1, 5'd1, 32'd0, rd);
        checkOutput("divZeroRead", 2, rd, 32'd1);
        doTransaction(2, 1'b0, 5'd0, 32'd1, rd);
        waitCycles(14);
        checkOutput("reenLock15", 2, 32'(cfgLock[2]), 32'd0);
        waitCycles(1);
        checkOutput("reenLock16", 2, 32'(cfgLock[2]), 32'd1);
        checkOutput("reenClkEn", 2, 32'(clkEn[2]), 32'd1);

        doTransaction(1, 1'b0, 5'd1, 32'd8, rd);
        doTransaction(1, 1'b0, 5'd1, 32'd4, rd);
        doTransaction(1, 1'b1, 5'd2, 32'd0, rd);
        checkOutput("statusPending", 1, rd, 32'h2);
        waitPulse(1, 20, w);
        checkOutput("div8Finish", 1, 32'(w), 32'd3);
        waitPulse(1, 20, g);
        checkOutput("div4Gap", 1, 32'(g), 32'd4);

        doTransaction(0, 1'b0, 5'd1, 32'd3, rd);
        waitCycles(2);
        doTransaction(0, 1'b0, 5'd1, 32'd5, rd);
        waitPulse(0, 20, w);
        checkOutput("div3Complete", 0, 32'(w), 32'd1);
        waitPulse(0, 20, g);
        checkOutput("div5Gap1", 0, 32'(g), 32'd5);
        waitPulse(0, 20, g);
        checkOutput("div5Gap2", 0, 32'(g), 32'd5);

        repeat (3000) begin
            @(negedge clock);
            applyStimulus();
        end
        @(negedge clock);
        cfgReq = '0;
        waitCycles(2);

        cfgReq[0] = 1'b1; cfgWrn[0] = 1'b0; cfgAdd[0] = 5'd1; cfgData[0] = 32'd7;
        @(posedge clock);
        #1;
        checkOutput("ackBeforeRst", 0, 32'(cfgAck[0]), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            checkOutput("rstMidAck", ch, 32'(cfgAck[ch]), 32'd0);
            checkOutput("rstMidData", ch, cfgRData[ch], 32'd0);
            checkOutput("rstMidLock", ch, 32'(cfgLock[ch]), 32'd0);
            checkOutput("rstMidClkEn", ch, 32'(clkEn[ch]), 32'd0);
        end
        cfgReq = '0;
        waitCycles(2);
        reset = 1'b0;
        waitCycles(1);

        cfgReq[1] = 1'b1; cfgWrn[1] = 1'b0; cfgAdd[1] = 5'd1; cfgData[1] = 32'd9;
        #2;
        reset = 1'b1;
        @(negedge clock);
        cfgReq = '0;
        waitCycles(1);
        reset = 1'b0;
        waitCycles(1);
        doTransaction(1, 1'b1, 5'd1, 32'd0, rd);
        checkOutput("lostWriteDiv", 1, rd, 32'(DRST));
        doTransaction(0, 1'b1, 5'd1, 32'd0, rd);
        checkOutput("rstDivCh0", 0, rd, 32'(DRST));
        waitCycles(20);

        checkOn = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
